seven_seg_scan: RTL

// - Consumes the four BCD stopwatch digits (sec_l, sec_h, min_l, min_h) and drives a 4-digit

---
 rtl/seven_seg_scan_pkg.sv | 28 ++
 rtl/seven_seg_scan_if.sv | 28 ++
 rtl/seven_seg_scan_bcd_to_seg.sv | 20 ++
 rtl/seven_seg_scan.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seven_seg_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = 2;

   typedef logic [3:0]       digit_t;
   typedef logic [6:0]       seg_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam seg_t SEG_DIGIT [10] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

endpackage : seven_seg_scan_pkg

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle: BCD digits and adjust controls from the stopwatch,
// segment/anode/decimal-point drive toward the board pins.
interface seven_seg_scan_if;
   import seven_seg_scan_pkg::*;

   digit_t     led_0;   // seconds low, rightmost
   digit_t     led_1;   // seconds high
   digit_t     led_2;   // minutes low
   digit_t     led_3;   // minutes high, leftmost
   logic       adj;     // adjust mode, enables blinking
   logic       sel;     // 1: seconds pair blinks, 0: minutes pair blinks
   seg_t       seg;     // active-low segments {g..a}
   logic [3:0] an;      // active-low anodes, an[i] = digit i
   logic       dp;      // active-low decimal point

   // Stopwatch side: supplies digits and controls, observes the pins.
   modport master (
      output led_0, led_1, led_2, led_3, adj, sel,
      input  seg, an, dp
   );

   // Scanner side.
   modport slave (
      input  led_0, led_1, led_2, led_3, adj, sel,
      output seg, an, dp
   );

endinterface : seven_seg_scan_if

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module seven_seg_scan_bcd_to_seg
   import seven_seg_scan_pkg::*;
(
   input  digit_t digit_i,
   output seg_t   seg_o
);

   // Look the digit up in the pattern table, falling back to a dash.
   always_comb begin
      // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
      seg_o = SEG_DASH;
      for (int i = 0; i < 10; i++) begin
         if (digit_i == 4'(i)) begin
            seg_o = SEG_DIGIT[i];
         end
      end
   end

endmodule : seven_seg_scan_bcd_to_seg

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display (MM.SS).
// Digits are latched into shadow registers once per frame so a frame never
// shows a mix of old and new values; the adjusted pair blinks in adjust mode.
module seven_seg_scan
   import seven_seg_scan_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,   // clk cycles per digit slot
   parameter int BLINK_TICKS = 250       // slot ticks per blink half-period
) (
   input  logic             clk,
   input  logic             rst,
   seven_seg_scan_if.slave  disp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
   localparam idx_t             IDX_LAST = idx_t'(NUM_DIGITS - 1);
   localparam idx_t             IDX_DP   = idx_t'(2);

   // Scan and blink state.
   logic [CNT_W-1:0] cnt_q, cnt_d;
   idx_t             idx_q, idx_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic             first_q;   // high on the first cycle after reset release

   // Frame-stable copy of the input digits.
   digit_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
   digit_t [NUM_DIGITS-1:0] live;

   // Registered pin drive.
   logic [3:0] an_q, an_d;
   seg_t       seg_q, seg_d;
   logic       dp_q, dp_d;

   logic   tick;
   logic   snapshot;
   logic   blank;
   digit_t view_digit;
   seg_t   dec_seg;

   assign live = {disp.led_3, disp.led_2, disp.led_1, disp.led_0};
   assign tick = (cnt_q == CNT_LAST);

   // A frame ends on the tick that leaves the last digit; the first cycle out
   // of reset also captures so the display never starts with stale zeros.
   assign snapshot = first_q | (tick & (idx_q == IDX_LAST));

   // On the capture cycle after reset the shadow still holds zeros, so show
   // the live digit that is being captured; otherwise show the frame copy.
   assign view_digit = first_q ? live[idx_q] : shadow_q[idx_q];

   // idx_q[1] separates the seconds pair (0,1) from the minutes pair (2,3).
   assign blank = disp.adj & blink_phase_q & (disp.sel ? ~idx_q[1] : idx_q[1]);

   seven_seg_scan_bcd_to_seg u_dec (
      .digit_i (view_digit),
      .seg_o   (dec_seg)
   );

   // Next-state for refresh counter, digit index, shadow digits and blink timer.
   always_comb begin
      cnt_d         = tick ? '0 : cnt_q + 1'b1;
      idx_d         = tick ? idx_q + 1'b1 : idx_q;
      shadow_d      = snapshot ? live : shadow_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!disp.adj) begin
         // Held visible outside adjust so entry always begins with a full lit half-period.
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Pin values for the digit currently selected by idx_q.
   always_comb begin
      an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = blank ? SEG_BLANK : dec_seg;
      dp_d  = ~((idx_q == IDX_DP) & ~blank);
   end

   // State and output registers with synchronous reset to all-off.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         first_q       <= 1'b1;
         shadow_q      <= '0;
         an_q          <= 4'b1111;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         first_q       <= 1'b0;
         shadow_q      <= shadow_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign disp.an  = an_q;
   assign disp.seg = seg_q;
   assign disp.dp  = dp_q;

endmodule : seven_seg_scan
